dsp_reg_file: RTL

- Architectural register file that consumes the memory stage's writeback result (write_back, regFile_write_en) plus the destination index carried down the pipeline.
- Serves two combinational read ports to decode.
- Holds a pending-write scoreboard, so decode can stall on read-after-write hazards until the memory stage retires the producing instruction.
- Sits between the memory stage (writer) and decode (reader and issuer).

---
 rtl/dsp_reg_file_pkg.sv | 13 +
 rtl/dsp_reg_file_if.sv | 31 +++
 rtl/dsp_reg_file_scoreboard.sv | 53 +++++
 rtl/dsp_reg_file.sv | 65 ++++++
 4 files changed

// File: rtl/dsp_reg_file_pkg.sv
// Shared sizing constants and helpers for the architectural register file.
// Register 0 is hardwired zero, so an access to index 0 never counts as live.
package dsp_reg_file_pkg;

   localparam int NUM_REGS = 16;
   localparam int ADDR_W   = 4;
   localparam int WORD_W   = 16;

   function automatic logic addr_live(input logic en, input logic [ADDR_W-1:0] addr);
      return en && (addr != '0);
   endfunction

endpackage

// File: rtl/dsp_reg_file_if.sv
// Bundle between the memory stage / decode (master) and the register file (slave).
interface dsp_reg_file_if;
   import dsp_reg_file_pkg::*;

   logic                wb_en;
   logic [ADDR_W-1:0]   wb_addr;
   logic [WORD_W-1:0]   wb_data;
   logic [ADDR_W-1:0]   rd_addr_a;
   logic [ADDR_W-1:0]   rd_addr_b;
   logic [WORD_W-1:0]   rd_data_a;
   logic [WORD_W-1:0]   rd_data_b;
   logic                issue_en;
   logic [ADDR_W-1:0]   issue_addr;
   logic                chk_en_a;
   logic                chk_en_b;
   logic                stall;
   logic [NUM_REGS-1:0] busy_vec;

   modport master (
      output wb_en, wb_addr, wb_data, rd_addr_a, rd_addr_b,
             issue_en, issue_addr, chk_en_a, chk_en_b,
      input  rd_data_a, rd_data_b, stall, busy_vec
   );

   modport slave (
      input  wb_en, wb_addr, wb_data, rd_addr_a, rd_addr_b,
             issue_en, issue_addr, chk_en_a, chk_en_b,
      output rd_data_a, rd_data_b, stall, busy_vec
   );

endinterface

// File: rtl/dsp_reg_file_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue and cleared on
// writeback, with the combinational read-after-write stall for the two decode ports.
module dsp_scoreboard
   import dsp_reg_file_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                issue_en,
   input  logic [ADDR_W-1:0]   issue_addr,
   input  logic                wb_en,
   input  logic [ADDR_W-1:0]   wb_addr,
   input  logic [ADDR_W-1:0]   rd_addr_a,
   input  logic [ADDR_W-1:0]   rd_addr_b,
   input  logic                chk_en_a,
   input  logic                chk_en_b,
   output logic                stall,
   output logic [NUM_REGS-1:0] busy_vec
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic                hazard_a;
   logic                hazard_b;

   // Set is applied after clear: the issuing instruction is younger than the retiring one.
   always_comb begin
      busy_d = busy_q;
      if (wb_en) begin
         busy_d[wb_addr] = 1'b0;
      end
      if (addr_live(issue_en, issue_addr)) begin
         busy_d[issue_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // A retiring write this cycle is forwarded by the bypass, so it does not stall.
   always_comb begin
      hazard_a = chk_en_a && busy_q[rd_addr_a] && !(wb_en && (wb_addr == rd_addr_a));
      hazard_b = chk_en_b && busy_q[rd_addr_b] && !(wb_en && (wb_addr == rd_addr_b));
      stall    = hazard_a || hazard_b;
   end

   assign busy_vec = busy_q;

endmodule

// File: rtl/dsp_reg_file.sv
// Architectural register file: writeback from the memory stage, two bypassed
// combinational read ports for decode, and the pending-write scoreboard.
module dsp_reg_file
   import dsp_reg_file_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   dsp_reg_file_if.slave  bus
);

   logic [WORD_W-1:0] regs_q [NUM_REGS];
   logic [WORD_W-1:0] regs_d [NUM_REGS];
   logic              wb_live;

   assign wb_live = addr_live(bus.wb_en, bus.wb_addr);

   // wb_data is only looked at when wb_en is high, so don't-care data never lands in the array.
   always_comb begin
      regs_d = regs_q;
      if (wb_live) begin
         regs_d[bus.wb_addr] = bus.wb_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   always_comb begin
      bus.rd_data_a = '0;
      bus.rd_data_b = '0;
      if (wb_live && (bus.wb_addr == bus.rd_addr_a)) begin
         bus.rd_data_a = bus.wb_data;
      end else if (bus.rd_addr_a != '0) begin
         bus.rd_data_a = regs_q[bus.rd_addr_a];
      end
      if (wb_live && (bus.wb_addr == bus.rd_addr_b)) begin
         bus.rd_data_b = bus.wb_data;
      end else if (bus.rd_addr_b != '0) begin
         bus.rd_data_b = regs_q[bus.rd_addr_b];
      end
   end

   dsp_scoreboard u_scoreboard (
      .clk        (clk),
      .rst_n      (rst_n),
      .issue_en   (bus.issue_en),
      .issue_addr (bus.issue_addr),
      .wb_en      (bus.wb_en),
      .wb_addr    (bus.wb_addr),
      .rd_addr_a  (bus.rd_addr_a),
      .rd_addr_b  (bus.rd_addr_b),
      .chk_en_a   (bus.chk_en_a),
      .chk_en_b   (bus.chk_en_b),
      .stall      (bus.stall),
      .busy_vec   (bus.busy_vec)
   );

endmodule
